// File: rtl/universal_shift_reg_n.sv
// universal_shift_reg_n: N-bit universal shift register
// single-step ops or autonomous multi-step bursts
module universal_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] q,
  output logic             sr_out,
  output logic             sl_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       mode_r, mode_n;
  logic [WIDTH-1:0] q_n;
  logic             nop_burst;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] d,
    input logic             si_r,
    input logic             si_l
  );
    logic [WIDTH-1:0] r;
    r = cur;
    case (m)
      3'b001:  r = {si_r, cur[WIDTH-1:1]};
      3'b010:  r = {cur[WIDTH-2:0], si_l};
      3'b011:  r = d;
      3'b100:  r = {cur[0], cur[WIDTH-1:1]};
      3'b101:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b110:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  // hold, load and reserved modes make a burst degenerate
  assign nop_burst = (shamt == '0) || (mode == 3'b000) ||
                     (mode == 3'b011) || (mode == 3'b111);

  // next-state, next-count and next-data selection
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_r;
    q_n     = q;
    unique case (state)
      IDLE: begin
        if (start) begin
          mode_n = mode;
          if (nop_burst) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
            cnt_n   = shamt;
          end
        end else if (en) begin
          q_n = apply_op(mode, q, din, sr_in, sl_in);
        end
      end
      RUN: begin
        q_n   = apply_op(mode_r, q, din, sr_in, sl_in);
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state, count, latched mode and data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_r <= '0;
      q      <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mode_r <= mode_n;
      q      <= q_n;
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign sr_out = q[0];
  assign sl_out = q[WIDTH-1];

endmodule
